// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit indices and multiplier FSM encoding for alu_seq_unit
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier, one partial product per cycle for WIDTH cycles
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               last_step;

  // FSM state register; reset aborts any run in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MUL_IDLE;
    else       state <= state_nxt;
  end

  // Next state and the accumulator value after this cycle's step.
  // done is high during the final step so the parent can latch the
  // finished product on the same edge that busy falls.
  always_comb begin
    state_nxt = state;
    last_step = 1'b0;
    acc_nxt   = acc + (mplier[0] ? mcand : '0);
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN: begin
        if (cnt == LAST) begin
          last_step = 1'b1;
          state_nxt = MUL_IDLE;
        end
      end
    endcase
  end

  // Operand capture on start, then shift multiplicand left / multiplier right each step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (state == MUL_IDLE && start) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (state == MUL_RUN) begin
      cnt    <= cnt + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end

  assign busy    = (state == MUL_RUN);
  assign done    = last_step;
  assign product = acc_nxt;

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - A/G registers, op mux and flags; ALU_MUL_EN adds the sequential multiplier
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buswire,
  input  logic             ain,
  input  logic             gin,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] aluout,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] a_reg, g_reg;
  logic [3:0]       flag_reg;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             res_c, res_v, res_wr;
  logic [3:0]       alu_flags;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [3:0]       mul_flags;

  // Single-cycle result and flags; MUL never writes G from here
  always_comb begin
    res    = '0;
    sum    = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_wr = 1'b1;
    shamt  = buswire[SHW-1:0];
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a_reg} + {1'b0, buswire};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_reg[WIDTH-1] == buswire[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a_reg} + {1'b0, ~buswire} + {{WIDTH{1'b0}}, 1'b1};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_reg[WIDTH-1] != buswire[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: res = a_reg & buswire;
      OP_OR:  res = a_reg | buswire;
      OP_XOR: res = a_reg ^ buswire;
      OP_SHL: res = (shamt >= SHW'(WIDTH)) ? '0 : (a_reg << shamt);
      OP_SHR: res = (shamt >= SHW'(WIDTH)) ? '0 : (a_reg >> shamt);
      default: res_wr = 1'b0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = res[WIDTH-1];
    alu_flags[FLAG_Z] = (res == '0);
    alu_flags[FLAG_C] = res_c;
    alu_flags[FLAG_V] = res_v;
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_start;
  logic               done_reg;

  assign mul_start = gin && !mul_busy && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_reg),
    .b       (buswire),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Flags for the finished product; any upper-half bit means overflow
  always_comb begin
    mul_res           = mul_product[WIDTH-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
  end

  // done is the registered copy of the final step, high the cycle after busy drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= mul_done;
  end

  assign busy = mul_busy;
  assign done = done_reg;
`else
  assign mul_busy  = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
  assign busy      = 1'b0;
  assign done      = 1'b0;
`endif

  // A load, and G/flag update from either a finishing multiply or an accepted single-cycle op
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      g_reg    <= '0;
      flag_reg <= '0;
    end else begin
      if (ain) a_reg <= buswire;
      if (mul_done) begin
        g_reg    <= mul_res;
        flag_reg <= mul_flags;
      end else if (gin && !mul_busy && res_wr) begin
        g_reg    <= res;
        flag_reg <= alu_flags;
      end
    end
  end

  assign aluout = g_reg;
  assign flags  = flag_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed and random checks of alu_seq_unit against an arithmetic model
module tb_alu_seq_unit;

  localparam int W = 16;
  localparam longint M = 65536;

  logic         clock, reset, ain, gin;
  logic [W-1:0] buswire;
  logic [2:0]   op;
  logic [W-1:0] aluout;
  logic [3:0]   flags;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  longint     exp_a, exp_g;
  logic [3:0] exp_f;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .buswire (buswire),
    .ain     (ain),
    .gin     (gin),
    .op      (op),
    .aluout  (aluout),
    .flags   (flags),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic longint to_signed(input longint v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Expected G and {N,Z,C,V} from plain integer arithmetic
  function automatic void ref_alu(input int o, input longint av, input longint bv,
                                  output longint g, output logic [3:0] f);
    longint r, sr, p;
    int     amt;
    logic   c, v;
    c = 1'b0;
    v = 1'b0;
    amt = int'(bv % 32);
    case (o)
      0: begin r = av + bv; c = (r >= M); sr = to_signed(av) + to_signed(bv);
               v = (sr > 32767) || (sr < -32768); g = r % M; end
      1: begin r = av - bv; c = (av >= bv); sr = to_signed(av) - to_signed(bv);
               v = (sr > 32767) || (sr < -32768); g = (r + M) % M; end
      2: g = av & bv;
      3: g = av | bv;
      4: g = av ^ bv;
      5: g = (amt >= W) ? 0 : ((av << amt) % M);
      6: g = (amt >= W) ? 0 : (av >> amt);
      default: begin p = av * bv; g = p % M; c = (p >= M); v = c; end
    endcase
    f = {g >= M / 2, g == 0, c, v};
  endfunction

  task automatic load_a(input logic [W-1:0] v);
    ain = 1'b1; gin = 1'b0; buswire = v;
    tick();
    ain = 1'b0;
    exp_a = longint'(v);
  endtask

  // One single-cycle op (optionally with a same-cycle A load); op 7 here is the disabled-MUL NOP
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] bv, input bit load);
    longint g;
    logic [3:0] f;
    ref_alu(int'(o), exp_a, longint'(bv), g, f);
    ain = load; gin = 1'b1; op = o; buswire = bv;
    tick();
    ain = 1'b0; gin = 1'b0;
    if (o != 3'b111) begin
      exp_g = g;
      exp_f = f;
    end
    if (load) exp_a = longint'(bv);
    check("op_g", 32'(aluout), 32'(exp_g));
    check("op_flags", 32'(flags), 32'(exp_f));
    check("op_busy", 32'(busy), 32'(0));
    check("op_done", 32'(done), 32'(0));
  endtask

  // Multiply with an A load and an ignored gin issued while it runs
  task automatic do_mul(input logic [W-1:0] bv);
    longint g;
    logic [3:0] f;
    int cycles, dones;
    ref_alu(7, exp_a, longint'(bv), g, f);
    gin = 1'b1; op = 3'b111; buswire = bv;
    tick();
    gin = 1'b0;
    cycles = 0;
    dones = 0;
    while (busy === 1'b1 && cycles < 40) begin
      gin = 1'b0; ain = 1'b0;
      if (cycles == 3) begin
        ain = 1'b1; buswire = W'($urandom);
        exp_a = longint'(buswire);
      end
      if (cycles == 5) begin
        gin = 1'b1; op = 3'($urandom_range(0, 7)); buswire = W'($urandom);
      end
      if (cycles == 7) check("mul_g_hold", 32'(aluout), 32'(exp_g));
      tick();
      cycles++;
      if (done === 1'b1) dones++;
    end
    gin = 1'b0; ain = 1'b0;
    exp_g = g;
    exp_f = f;
    check("mul_busy_cycles", 32'(cycles), 32'(W));
    check("mul_done_count", 32'(dones), 32'(1));
    check("mul_g", 32'(aluout), 32'(exp_g));
    check("mul_flags", 32'(flags), 32'(exp_f));
    tick();
    check("mul_done_clear", 32'(done), 32'(0));
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; ain = 1'b0; gin = 1'b0; op = '0; buswire = '0;
    exp_a = 0; exp_g = 0; exp_f = '0;
    #12;
    check("rst_g", 32'(aluout), 32'(0));
    check("rst_flags", 32'(flags), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();

    load_a(16'h7FFF);
    do_op(3'b000, 16'h0001, 1'b0);
    check("add_const_g", 32'(aluout), 32'h8000);
    check("add_const_f", 32'(flags), 32'b1001);

    load_a(16'h0005);
    do_op(3'b001, 16'h0005, 1'b0);
    check("sub_eq_f", 32'(flags), 32'b0110);
    do_op(3'b001, 16'h0006, 1'b0);
    check("sub_borrow_g", 32'(aluout), 32'hFFFF);
    check("sub_borrow_f", 32'(flags), 32'b1000);

`ifdef ALU_MUL_EN
    load_a(16'd300);
    do_mul(16'd200);
    check("mul_const_g", 32'(aluout), 32'hEA60);
    check("mul_const_f", 32'(flags), 32'b1000);
    load_a(16'h0100);
    do_mul(16'h0100);
    check("mul_ovf_f", 32'(flags), 32'b0111);
`else
    load_a(16'd300);
    do_op(3'b111, 16'd200, 1'b0);
    check("nop_g", 32'(aluout), 32'hFFFF);
`endif

    load_a(16'h0001);
    do_op(3'b101, 16'd16, 1'b0);
    check("shl_wide_g", 32'(aluout), 32'h0000);
    do_op(3'b000, 16'h0003, 1'b1);
    check("ain_gin_g", 32'(aluout), 32'h0004);
    do_op(3'b000, 16'h0000, 1'b0);
    check("ain_gin_a", 32'(aluout), 32'h0003);

`ifdef ALU_MUL_EN
    load_a(16'd300);
    gin = 1'b1; op = 3'b111; buswire = 16'd200;
    tick();
    gin = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_g", 32'(aluout), 32'(0));
    check("rst_mid_flags", 32'(flags), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();
    exp_a = 0; exp_g = 0; exp_f = '0;
    load_a(16'd300);
    do_mul(16'd200);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (($urandom & 3) == 0) load_a(W'($urandom));
`ifdef ALU_MUL_EN
      if (o == 3'b111) do_mul(W'($urandom));
      else do_op(o, W'($urandom), 1'($urandom));
`else
      do_op(o, W'($urandom), 1'($urandom));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
